reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 93 +++++++++
 tb/tb_reg_file_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file: two asynchronous read ports, one write port,
// and a post-reset clear sweep that zeroes every entry before READY rises.
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] R1,
    input  logic [ADDR_W-1:0] R2,
    input  logic [ADDR_W-1:0] RD,
    input  logic [XLEN-1:0]   RD_DATA,
    input  logic              WRITE_ENABLE,
    output logic [XLEN-1:0]   R1_DATA,
    output logic [XLEN-1:0]   R2_DATA,
    output logic              READY
);

    localparam int N = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [XLEN-1:0]   regs [N];
    logic              run;
    logic              clr;
    logic              qw;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter only advances while sweeping, so it parks at N and never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == CLEAR) begin
            cnt_nxt = cnt + (ADDR_W + 1)'(1);
            if (cnt[ADDR_W-1:0] == ADDR_W'(N - 1)) begin
                state_nxt = RUN;
            end
        end
    end

    // RESET masks the outputs combinationally so nothing leaks during the reset cycle.
    always_comb begin
        run   = (state == RUN) && !RESET;
        clr   = (state == CLEAR) && !RESET;
        READY = run;
        qw    = run && WRITE_ENABLE && !((ZERO_REG != 0) && (RD == '0));
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            regs[cnt[ADDR_W-1:0]] <= '0;
        end else if (qw) begin
            regs[RD] <= RD_DATA;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (!run) begin
            return '0;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end
        if ((BYPASS != 0) && qw && (addr == RD)) begin
            return RD_DATA;
        end
        return regs[addr];
    endfunction

    always_comb begin
        R1_DATA = read_port(R1);
        R2_DATA = read_port(R2);
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three configurations share one reset and
// are checked every cycle against a simple array model of the register file.
module tb_reg_file_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET;
    logic [4:0]  r1, r2, rd;
    logic [31:0] d;
    logic        we;
    logic [2:0]  w_r1, w_r2, w_rd;
    logic [63:0] w_d;
    logic        w_we;

    logic [31:0] a_r1d, a_r2d, b_r1d, b_r2d;
    logic [63:0] w_r1d, w_r2d;
    logic        a_rdy, b_rdy, w_rdy;

    reg_file_param dut_a (
        .CLK(CLK), .RESET(RESET), .R1(r1), .R2(r2), .RD(rd), .RD_DATA(d),
        .WRITE_ENABLE(we), .R1_DATA(a_r1d), .R2_DATA(a_r2d), .READY(a_rdy)
    );

    reg_file_param #(.XLEN(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .R1(r1), .R2(r2), .RD(rd), .RD_DATA(d),
        .WRITE_ENABLE(we), .R1_DATA(b_r1d), .R2_DATA(b_r2d), .READY(b_rdy)
    );

    reg_file_param #(.XLEN(64), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_w (
        .CLK(CLK), .RESET(RESET), .R1(w_r1), .R2(w_r2), .RD(w_rd), .RD_DATA(w_d),
        .WRITE_ENABLE(w_we), .R1_DATA(w_r1d), .R2_DATA(w_r2d), .READY(w_rdy)
    );

    typedef struct {
        logic [31:0] a1, a2, b1, b2;
        logic [63:0] w1, w2;
        logic        rdy, rdy_w;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain arrays plus a count of clear edges since reset.
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic [63:0] mem_w [8];
    int          edges   = 0;
    int          edges_w = 0;
    bit          rdy_m   = 0;
    bit          rdy_wm  = 0;

    logic        nw_we;
    logic [2:0]  nw_rd, nw_r1, nw_r2;
    logic [63:0] nw_d;

    task automatic commit();
        if (RESET) begin
            edges = 0; rdy_m = 0; edges_w = 0; rdy_wm = 0;
        end else begin
            if (!rdy_m) begin
                edges++;
                if (edges == 32) begin
                    rdy_m = 1;
                    for (int i = 0; i < 32; i++) begin
                        mem_a[i] = '0;
                        mem_b[i] = '0;
                    end
                end
            end else begin
                if (we && rd != 0) mem_a[rd] = d;
                if (we) mem_b[rd] = d;
            end
            if (!rdy_wm) begin
                edges_w++;
                if (edges_w == 8) begin
                    rdy_wm = 1;
                    for (int i = 0; i < 8; i++) mem_w[i] = '0;
                end
            end else if (w_we && w_rd != 0) begin
                mem_w[w_rd] = w_d;
            end
        end
    endtask

    function automatic logic [31:0] pred_a(input logic [4:0] addr, input bit ok, input bit q);
        if (!ok || addr == 0) return '0;
        if (q && addr == rd) return d;
        return mem_a[addr];
    endfunction

    function automatic logic [63:0] pred_w(input logic [2:0] addr, input bit ok, input bit q);
        if (!ok || addr == 0) return '0;
        if (q && addr == w_rd) return w_d;
        return mem_w[addr];
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit   qa, qw;
        e.rdy   = rdy_m && !RESET;
        e.rdy_w = rdy_wm && !RESET;
        qa      = e.rdy && we && rd != 0;
        qw      = e.rdy_w && w_we && w_rd != 0;
        e.a1    = pred_a(r1, e.rdy, qa);
        e.a2    = pred_a(r2, e.rdy, qa);
        e.b1    = e.rdy ? mem_b[r1] : 32'h0;
        e.b2    = e.rdy ? mem_b[r2] : 32'h0;
        e.w1    = pred_w(w_r1, e.rdy_w, qw);
        e.w2    = pred_w(w_r2, e.rdy_w, qw);
        return e;
    endfunction

    task automatic step(input bit rst, input bit wen, input logic [4:0] a_rd,
                        input logic [4:0] a_r1, input logic [4:0] a_r2,
                        input logic [31:0] a_d, input bit wrand);
        @(posedge CLK);
        commit();
        #1;
        RESET = rst; we = wen; rd = a_rd; r1 = a_r1; r2 = a_r2; d = a_d;
        if (wrand) begin
            w_we = 1'($urandom_range(0, 1));
            w_rd = 3'($urandom); w_r1 = 3'($urandom); w_r2 = 3'($urandom);
            w_d  = {$urandom, $urandom};
        end else begin
            w_we = nw_we; w_rd = nw_rd; w_r1 = nw_r1; w_r2 = nw_r2; w_d = nw_d;
        end
        sb.push_back(predict());
    endtask

    task automatic step_rand(input bit rst);
        step(rst, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom),
             $urandom, 1);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ready_a", 64'(a_rdy), 64'(e.rdy));
            chk("ready_b", 64'(b_rdy), 64'(e.rdy));
            chk("ready_w", 64'(w_rdy), 64'(e.rdy_w));
            chk("r1_a", 64'(a_r1d), 64'(e.a1));
            chk("r2_a", 64'(a_r2d), 64'(e.a2));
            chk("r1_b", 64'(b_r1d), 64'(e.b1));
            chk("r2_b", 64'(b_r2d), 64'(e.b2));
            chk("r1_w", w_r1d, e.w1);
            chk("r2_w", w_r2d, e.w2);
        end
    end

    initial begin
        RESET = 1'b1; we = 0; rd = 0; r1 = 0; r2 = 0; d = 0;
        w_we = 0; w_rd = 0; w_r1 = 0; w_r2 = 0; w_d = 0;
        nw_we = 0; nw_rd = 0; nw_r1 = 0; nw_r2 = 0; nw_d = 0;

        // Reset, then the sweep with writes hammering entry 7 that must be ignored
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++)
            step(0, 1, (i % 2) ? 5'd7 : 5'($urandom), 5'($urandom), 5'($urandom),
                 32'hFFFF_FFFF, 1);
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 5'(i), 5'(31 - i), 0, 1);

        // Full-width write and readback on the 64-bit instance
        nw_we = 1; nw_rd = 3'd7; nw_d = 64'hFFFF_FFFF_FFFF_FFFF; nw_r1 = 0; nw_r2 = 3'd7;
        step(0, 0, 0, 0, 0, 0, 0);
        nw_we = 0;
        step(0, 0, 0, 0, 0, 0, 0);

        // Same-cycle forwarding vs. next-cycle visibility
        step(0, 1, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF, 1);
        step(0, 0, 0, 5'd5, 5'd5, 0, 1);

        // Writes to address 0
        step(0, 1, 5'd0, 5'd0, 5'd0, 32'h1234_5678, 1);
        step(0, 0, 0, 5'd0, 5'd0, 0, 1);

        // Back-to-back writes to one address
        step(0, 1, 5'd9, 5'd9, 5'd9, 32'hAAAA_0001, 1);
        step(0, 1, 5'd9, 5'd9, 5'd9, 32'hBBBB_0002, 1);
        step(0, 0, 0, 5'd9, 5'd9, 0, 1);

        for (int i = 0; i < 400; i++)
            step_rand($urandom_range(0, 149) == 0);

        // Fill, then interrupt a sweep at CNT=10 and check the restarted sweep
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++) step_rand(0);
        for (int i = 1; i < 32; i++)
            step(0, 1, 5'(i), 5'($urandom), 5'($urandom), 32'(i), 1);
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step_rand(0);
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++) step_rand(0);
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 5'(i), 5'(31 - i), 0, 1);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
